// File: rtl/data_mem_responder.sv
// Data-memory responder: word RAM, completion/result register and an
// in-order trace FIFO of every accepted store.
module data_mem_responder #(
    parameter int          DEPTH       = 64,
    parameter logic [31:0] RESULT_ADDR = 32'd20,
    parameter int          FIFO_DEPTH  = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] dataadr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        done,
    output logic [31:0] result,
    output logic        err_misaligned,
    output logic        err_range,
    output logic        trace_valid,
    input  logic        trace_ready,
    output logic [31:0] trace_addr,
    output logic [31:0] trace_data,
    output logic        trace_overflow,
    output logic [15:0] store_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int FW = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } trace_t;

    logic [31:0]   ram [DEPTH];
    trace_t        fifo [FIFO_DEPTH];
    logic [FW-1:0] wptr, rptr;
    logic [FW:0]   count;

    logic          aligned, in_range;
    logic          bad_align, bad_range, accept;
    logic          full, pop, push;
    logic [AW-1:0] idx;

    assign aligned  = (dataadr[1:0] == 2'b00);
    assign in_range = (dataadr[31:2] < 30'(DEPTH));
    assign idx      = dataadr[AW+1:2];

    always_comb begin
        bad_align = 1'b0;
        bad_range = 1'b0;
        accept    = 1'b0;
        if (memwrite) begin
            unique case (1'b1)
                !aligned:             bad_align = 1'b1;
                aligned && !in_range: bad_range = 1'b1;
                aligned && in_range:  accept    = 1'b1;
            endcase
        end
    end

    assign readdata    = (aligned && in_range) ? ram[idx] : 32'd0;

    assign trace_valid = (count != '0);
    assign full        = (count == (FW+1)'(FIFO_DEPTH));
    assign pop         = trace_valid && trace_ready;
    // A pop in the same cycle frees the slot a full-FIFO push needs.
    assign push        = accept && (!full || pop);
    assign trace_addr  = trace_valid ? fifo[rptr].addr : 32'd0;
    assign trace_data  = trace_valid ? fifo[rptr].data : 32'd0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= '0;
            done           <= 1'b0;
            result         <= '0;
            err_misaligned <= 1'b0;
            err_range      <= 1'b0;
            trace_overflow <= 1'b0;
            store_count    <= '0;
            wptr           <= '0;
            rptr           <= '0;
            count          <= '0;
        end else begin
            if (bad_align) err_misaligned <= 1'b1;
            if (bad_range) err_range      <= 1'b1;
            if (accept) begin
                ram[idx] <= writedata;
                if (store_count != 16'hFFFF)
                    store_count <= store_count + 16'd1;
                if (dataadr == RESULT_ADDR && !done) begin
                    done   <= 1'b1;
                    result <= writedata;
                end
                if (!push) trace_overflow <= 1'b1;
            end
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
        end
    end

    // Entry storage needs no reset: the head is masked while empty.
    always_ff @(posedge clk) begin
        if (reset && push) fifo[wptr] <= '{addr: dataadr, data: writedata};
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder.
// Inputs change on the falling edge; outputs are checked there too.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        memwrite;
    logic [31:0] dataadr;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        done;
    logic [31:0] result;
    logic        err_misaligned;
    logic        err_range;
    logic        trace_valid;
    logic        trace_ready;
    logic [31:0] trace_addr;
    logic [31:0] trace_data;
    logic        trace_overflow;
    logic [15:0] store_count;

    int checks = 0;
    int passes = 0;

    data_mem_responder dut (
        .clk            (clk),
        .reset          (reset),
        .memwrite       (memwrite),
        .dataadr        (dataadr),
        .writedata      (writedata),
        .readdata       (readdata),
        .done           (done),
        .result         (result),
        .err_misaligned (err_misaligned),
        .err_range      (err_range),
        .trace_valid    (trace_valid),
        .trace_ready    (trace_ready),
        .trace_addr     (trace_addr),
        .trace_data     (trace_data),
        .trace_overflow (trace_overflow),
        .store_count    (store_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        memwrite  = 1'b1;
        dataadr   = a;
        writedata = d;
        tick();
        memwrite  = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [31:0] a,
                      input logic [31:0] exp);
        dataadr = a;
        #1;
        check(tag, readdata, exp);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    task automatic drain_one(input string tag, input logic [31:0] a,
                             input logic [31:0] d);
        check({tag, "_valid"}, 32'(trace_valid), 32'd1);
        check({tag, "_addr"}, trace_addr, a);
        check({tag, "_data"}, trace_data, d);
        trace_ready = 1'b1;
        tick();
        trace_ready = 1'b0;
    endtask

    initial begin
        reset       = 1'b0;
        memwrite    = 1'b1;
        dataadr     = 32'd0;
        writedata   = 32'hDEAD_BEEF;
        trace_ready = 1'b0;
        @(negedge clk);
        tick();
        tick();
        memwrite = 1'b0;
        reset    = 1'b1;

        check("rst_done", 32'(done), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_errm", 32'(err_misaligned), 32'd0);
        check("rst_errr", 32'(err_range), 32'd0);
        check("rst_valid", 32'(trace_valid), 32'd0);
        check("rst_taddr", trace_addr, 32'd0);
        check("rst_tdata", trace_data, 32'd0);
        check("rst_ovf", 32'(trace_overflow), 32'd0);
        check("rst_count", 32'(store_count), 32'd0);
        rd("rst_rd0", 32'd0, 32'd0);
        rd("rst_rd80", 32'd80, 32'd0);

        // Program end: sw of 0 to the result address.
        wr(32'd20, 32'd0);
        check("prog_done", 32'(done), 32'd1);
        check("prog_result", result, 32'd0);
        check("prog_count", 32'(store_count), 32'd1);
        check("prog_errm", 32'(err_misaligned), 32'd0);
        check("prog_errr", 32'(err_range), 32'd0);
        drain_one("prog_head", 32'd20, 32'd0);
        check("prog_empty", 32'(trace_valid), 32'd0);

        do_reset();
        check("rst2_done", 32'(done), 32'd0);
        memwrite  = 1'b1;
        dataadr   = 32'd80;
        writedata = 32'h1234;
        #1;
        check("nofwd_rd80", readdata, 32'd0);
        tick();
        memwrite = 1'b0;
        rd("rd80", 32'd80, 32'h1234);
        wr(32'd20, 32'h5);
        wr(32'd20, 32'h9);
        check("res_first", result, 32'h5);
        check("res_done", 32'(done), 32'd1);
        rd("rd20", 32'd20, 32'h9);
        check("count3", 32'(store_count), 32'd3);

        wr(32'd22, 32'hAAAA);
        check("mis_flag", 32'(err_misaligned), 32'd1);
        check("mis_count", 32'(store_count), 32'd3);
        rd("mis_rd20", 32'd20, 32'h9);
        rd("mis_rd22", 32'd22, 32'd0);
        wr(32'd256, 32'hBBBB);
        check("rng_flag", 32'(err_range), 32'd1);
        check("rng_count", 32'(store_count), 32'd3);
        rd("rng_rd", 32'd256, 32'd0);
        rd("rng_rd0", 32'd0, 32'd0);
        drain_one("q0", 32'd80, 32'h1234);
        drain_one("q1", 32'd20, 32'h5);
        drain_one("q2", 32'd20, 32'h9);
        check("q_empty", 32'(trace_valid), 32'd0);
        check("sticky_m", 32'(err_misaligned), 32'd1);

        // Nine stores into an eight-entry FIFO with no pops.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            wr(32'(4 * i), 32'(100 + i));
            if (i == 7) check("ovf_pre", 32'(trace_overflow), 32'd0);
        end
        check("ovf_set", 32'(trace_overflow), 32'd1);
        check("ovf_count", 32'(store_count), 32'd9);
        rd("ovf_rd32", 32'd32, 32'd108);
        for (int i = 0; i < 8; i++)
            drain_one($sformatf("ovf_q%0d", i), 32'(4 * i), 32'(100 + i));
        check("ovf_empty", 32'(trace_valid), 32'd0);

        // Full FIFO with simultaneous push and pop every cycle.
        do_reset();
        for (int i = 0; i < 8; i++) wr(32'(4 * i), 32'(i));
        trace_ready = 1'b1;
        memwrite    = 1'b1;
        for (int k = 0; k < 20; k++) begin
            check($sformatf("strm_a%0d", k), trace_addr, 32'(4 * k));
            dataadr   = 32'(32 + 4 * k);
            writedata = 32'(8 + k);
            tick();
        end
        memwrite = 1'b0;
        check("strm_ovf", 32'(trace_overflow), 32'd0);
        for (int k = 20; k < 28; k++) begin
            check($sformatf("strm_v%0d", k), 32'(trace_valid), 32'd1);
            check($sformatf("strm_a%0d", k), trace_addr, 32'(4 * k));
            tick();
        end
        check("strm_empty", 32'(trace_valid), 32'd0);
        check("strm_count", 32'(store_count), 32'd28);
        trace_ready = 1'b0;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder end of the core's data-memory store interface (memwrite/dataadr/writedata) and its load path (readdata).
- Holds word-addressed data RAM, a memory-mapped result register that signals program completion, and a trace FIFO of every accepted store.
- The trace FIFO lets a checker drain stores in order instead of sampling the bus on clock edges.
- Sits beside the single-cycle core inside top; replaces the bare dmem.

Parameters:
- DEPTH, 64, number of 32-bit RAM words (power of two, ≤256)
- RESULT_ADDR, 32'd20, byte address whose store raises done and latches result
- FIFO_DEPTH, 8, trace FIFO entries (power of two, ≥2)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset (asserted when 0, sampled on rising clk)
- memwrite  input  1  store strobe from core, one store per cycle when high
- dataadr  input  32  byte address from core ALU result
- writedata  input  32  store data from core
- readdata  output  32  load data to core, combinational
- done  output  1  sticky: a store to RESULT_ADDR has committed
- result  output  32  data of the first store to RESULT_ADDR
- err_misaligned  output  1  sticky: store seen with dataadr[1:0]≠0
- err_range  output  1  sticky: aligned store beyond DEPTH words
- trace_valid  output  1  FIFO non-empty
- trace_ready  input  1  checker pop; pop occurs when trace_valid & trace_ready
- trace_addr  output  32  head entry address
- trace_data  output  32  head entry data
- trace_overflow  output  1  sticky: accepted store not logged because FIFO full
- store_count  output  16  accepted stores, saturates at 16'hFFFF

Behaviour:
- Reset (reset==0 at posedge): RAM cleared to 0. done, result, all error flags, trace_overflow and store_count go to 0. FIFO emptied; trace_valid=0. trace_addr/trace_data=0 while empty.
- Reset mid-operation overrides any store or pop in the same cycle.
- Word index = dataadr[log2(DEPTH)+1:2]. In range means dataadr[31:2] < DEPTH.
- Read path:
  - readdata = RAM[index] combinationally when aligned and in range; otherwise 0.
  - No read flags are raised.
  - A same-cycle store is not forwarded; readdata shows the old word until the edge.
- Store acceptance at posedge with memwrite=1:
  - Misaligned: not accepted. err_misaligned set; RAM, FIFO and count unchanged.
  - Aligned but out of range: not accepted. err_range set.
  - Otherwise accepted: RAM[index] ← writedata. store_count +1, saturating.
- Result register:
  - An accepted store with dataadr==RESULT_ADDR also writes RAM.
  - On the first such store: result ← writedata, done ← 1.
  - Later stores to RESULT_ADDR update RAM only; result holds its first value.
- Trace FIFO:
  - Circular buffer with read/write pointers and an occupancy count 0..FIFO_DEPTH.
  - Each accepted store pushes {dataadr, writedata}.
  - Head is visible combinationally; latency from push edge to trace_valid is one cycle.
  - Full with no pop: push dropped and trace_overflow set; the RAM write still happens.
  - Full with a same-cycle pop: pop and push both succeed; count stays FIFO_DEPTH and no overflow.
  - Empty with a same-cycle push: trace_ready is ignored (trace_valid=0); entry appears next cycle.
  - Pointers wrap modulo FIFO_DEPTH.
  - Rejected stores are never pushed.
- Sticky flags clear only on reset.

Test Plan:
- Reset then no activity:
  - All outputs 0 and readdata=0 at any aligned address.
  - Hold reset low across a memwrite → no RAM change, count 0.
- Run the addi/beq/sw program (store 0 to addr 20):
  - done=1 and result=0 the cycle after the store.
  - Trace head = {20, 0}; store_count=1; no error flags.
- Store 0x1234 to 80, then read 80:
  - readdata=0x1234 after the edge and 0 before it.
  - Store 0x5 to 20, then 0x9 to 20 → result=0x5, RAM[5]=0x9, count=3.
- Store to 22:
  - err_misaligned=1; count, FIFO and RAM unchanged.
  - Store to 4*DEPTH → err_range=1, readdata there=0.
- trace_ready=0 with FIFO_DEPTH+1 stores to 0,4,…:
  - Overflow set on the 9th store; RAM still updated.
  - Drain → entries 0..28 in order, trace_valid falls after the 8th pop.
- Fill FIFO, then hold memwrite and trace_ready high for 20 cycles:
  - Count stays 8, no overflow.
  - Popped addresses are contiguous with no gaps across pointer wrap.
